fetch_stage_ctrl: RTL and testbench



---
 rtl/fetch_stage_ctrl_pkg.sv | 15 +
 rtl/fetch_stage_ctrl_if_id_reg.sv | 34 +++
 rtl/fetch_stage_ctrl.sv | 129 ++++++++++++
 tb/tb_fetch_stage_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch control stage.
// Holds the FSM state encoding, reset PC, bubble instruction and word width.
package fetch_stage_ctrl_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_ctrl_if_id_reg.sv
// IF/ID pipeline register: {instr, pc4, valid} with load, hold and clear-to-bubble.
// Clear beats load so a flush always wins over a same-cycle capture.
module fetch_stage_ctrl_if_id_reg
  import fetch_stage_ctrl_pkg::*;
#(
  parameter int                 N         = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [N-1:0]       d_pc4,
  output logic [INSTR_W-1:0] instr,
  output logic [N-1:0]       pc4,
  output logic               valid
);

  localparam int W = INSTR_W + N + 1;

  logic [W-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      data_reg <= {NOP_INSTR, {N{1'b0}}, 1'b0};
    end else if (load) begin
      data_reg <= {d_instr, d_pc4, 1'b1};
    end
  end

  assign {instr, pc4, valid} = data_reg;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch control: next-PC mux, imem handshake, one-entry skid for ID stalls,
// and redirect handling that drops a response still in flight.
module fetch_stage_ctrl
  import fetch_stage_ctrl_pkg::*;
#(
  parameter int                 N         = 32,
  parameter logic [N-1:0]       RESET_PC  = N'(RESET_PC_DEFAULT),
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       pc_value,
  output logic [N-1:0]       new_pc,
  output logic               imem_req,
  output logic [N-1:0]       imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               id_stall,
  input  logic               redirect_valid,
  input  logic [N-1:0]       redirect_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [N-1:0]       if_id_pc4,
  output logic               if_id_valid
);

  fetch_state_e       state_reg, state_next;
  logic [INSTR_W-1:0] skid_instr_reg;
  logic [N-1:0]       skid_pc4_reg;
  logic [N-1:0]       req_addr_reg;
  logic [N-1:0]       pc_plus4;
  logic               ifid_load, ifid_clear, skid_load, req_addr_load;
  logic [INSTR_W-1:0] ifid_d_instr;
  logic [N-1:0]       ifid_d_pc4;

  assign pc_plus4 = pc_value + N'(4);

  always_comb begin
    state_next    = state_reg;
    new_pc        = pc_value;
    imem_req      = 1'b0;
    imem_addr     = pc_value;
    ifid_load     = 1'b0;
    ifid_clear    = 1'b0;
    ifid_d_instr  = imem_rdata;
    ifid_d_pc4    = pc_plus4;
    skid_load     = 1'b0;
    req_addr_load = 1'b0;

    case (state_reg)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          new_pc = pc_plus4;
          if (id_stall) begin
            skid_load  = 1'b1;
            state_next = HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end else begin
          req_addr_load = 1'b1;
          ifid_clear    = !id_stall;
        end
      end
      HOLD: begin
        ifid_d_instr = skid_instr_reg;
        ifid_d_pc4   = skid_pc4_reg;
        if (!id_stall) begin
          ifid_load  = 1'b1;
          state_next = FETCH;
        end
      end
      DROP: begin
        // Keep presenting the stale address until the memory answers it.
        imem_req   = 1'b1;
        imem_addr  = req_addr_reg;
        ifid_clear = !id_stall;
        if (imem_ready) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    // A flush overrides stalls and captures; an unanswered request must be dropped.
    if (redirect_valid) begin
      new_pc     = redirect_pc;
      ifid_clear = 1'b1;
      ifid_load  = 1'b0;
      skid_load  = 1'b0;
      state_next = ((state_reg == FETCH || state_reg == DROP) && !imem_ready) ? DROP : FETCH;
    end

    if (reset) begin
      imem_req = 1'b0;
      new_pc   = RESET_PC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= FETCH;
      skid_instr_reg <= NOP_INSTR;
      skid_pc4_reg   <= '0;
      req_addr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (skid_load) begin
        skid_instr_reg <= imem_rdata;
        skid_pc4_reg   <= pc_plus4;
      end
      if (req_addr_load) req_addr_reg <= pc_value;
    end
  end

  fetch_stage_ctrl_if_id_reg #(
    .N        (N),
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (ifid_load),
    .clear  (ifid_clear),
    .d_instr(ifid_d_instr),
    .d_pc4  (ifid_d_pc4),
    .instr  (if_id_instr),
    .pc4    (if_id_pc4),
    .valid  (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Bench for fetch_stage_ctrl: a PC register and a fixed-latency memory model around the DUT,
// directed cycle vectors, and a scoreboard drained whenever ID accepts an instruction.
module tb_fetch_stage_ctrl;
  import fetch_stage_ctrl_pkg::*;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;
  localparam logic [31:0] RPC = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_value, new_pc, imem_addr, imem_rdata, redirect_pc;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        imem_req, imem_ready, id_stall, redirect_valid, if_id_valid;
  int          mem_wait = 0;
  int          wait_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic        prev_pending = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  fetch_stage_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .pc_value      (pc_value),
    .new_pc        (new_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .id_stall      (id_stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign imem_ready = imem_req && (wait_cnt >= mem_wait);

  // PC register and memory wait counter
  always @(posedge clk) begin
    pc_value <= new_pc;
    if (reset || !imem_req || imem_ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic push(input logic [31:0] addr, input logic [31:0] pc4);
    exp_q.push_back(exp_t'({mem_word(addr), pc4}));
  endtask

  task automatic cyc(input logic r, input int w, input logic s, input logic rv, input logic [31:0] rp);
    @(posedge clk);
    #1;
    reset = r; mem_wait = w; id_stall = s; redirect_valid = rv; redirect_pc = rp;
    @(negedge clk);
  endtask

  // Monitor: scoreboard on every ID accept, plus request-stability protocol check
  always @(negedge clk) begin
    exp_t e;
    if (if_id_valid === 1'b1 && id_stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got pc4=%h instr=%h expected none", if_id_pc4, if_id_instr);
      end else begin
        e = exp_q.pop_front();
        $display("txn pc4=%h instr=%h", if_id_pc4, if_id_instr);
        chk("ifid_instr", if_id_instr, e.instr);
        chk("ifid_pc4", if_id_pc4, e.pc4);
      end
    end
    if (prev_pending && reset === 1'b0) begin
      chk("req_held", {31'b0, imem_req}, 32'd1);
      chk("addr_held", imem_addr, prev_addr);
    end
    prev_pending = (reset === 1'b0) && (imem_req === 1'b1) && (imem_ready === 1'b0);
    prev_addr    = imem_addr;
  end

  initial begin
    reset = H; id_stall = L; redirect_valid = L; redirect_pc = 32'h0;
    cyc(H, 0, L, L, 32'h0);
    cyc(H, 0, L, L, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_new_pc", new_pc, RPC);
    chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc4, 32'h0);
    cyc(H, 0, L, L, 32'h0);
    // zero-wait memory
    cyc(L, 0, L, L, 32'h0); chk("zw_new_pc", new_pc, 32'h0040_0004); push(32'h0040_0000, 32'h0040_0004);
    cyc(L, 0, L, L, 32'h0); chk("zw_valid", {31'b0, if_id_valid}, 32'd1); push(32'h0040_0004, 32'h0040_0008);
    cyc(L, 0, L, L, 32'h0); push(32'h0040_0008, 32'h0040_000C);
    cyc(L, 0, L, L, 32'h0); push(32'h0040_000C, 32'h0040_0010);
    // one wait state per fetch
    cyc(L, 1, L, L, 32'h0); chk("lat_new_pc", new_pc, 32'h0040_0010); chk("lat_addr", imem_addr, 32'h0040_0010);
    cyc(L, 1, L, L, 32'h0); chk("lat_bubble", {31'b0, if_id_valid}, 32'd0); push(32'h0040_0010, 32'h0040_0014);
    cyc(L, 1, L, L, 32'h0);
    cyc(L, 1, L, L, 32'h0); push(32'h0040_0014, 32'h0040_0018);
    // three-cycle ID stall coinciding with a response
    cyc(L, 0, L, L, 32'h0); push(32'h0040_0018, 32'h0040_001C);
    cyc(L, 0, H, L, 32'h0); chk("stall_new_pc", new_pc, 32'h0040_0020); push(32'h0040_001C, 32'h0040_0020);
    cyc(L, 0, H, L, 32'h0); chk("hold_req", {31'b0, imem_req}, 32'd0); chk("hold_pc4", if_id_pc4, 32'h0040_001C);
    cyc(L, 0, H, L, 32'h0); chk("hold_valid", {31'b0, if_id_valid}, 32'd1); chk("hold_pc4b", if_id_pc4, 32'h0040_001C);
    cyc(L, 0, L, L, 32'h0); chk("release_req", {31'b0, imem_req}, 32'd0); chk("release_new_pc", new_pc, 32'h0040_0020);
    cyc(L, 0, L, L, 32'h0); chk("skid_pc4", if_id_pc4, 32'h0040_0020); push(32'h0040_0020, 32'h0040_0024);
    cyc(L, 0, L, L, 32'h0); push(32'h0040_0024, 32'h0040_0028);
    // redirect while a response is outstanding
    cyc(L, 1, L, H, 32'h0040_0100); chk("redir_new_pc", new_pc, 32'h0040_0100);
    cyc(L, 1, L, L, 32'h0);
    chk("drop_addr", imem_addr, 32'h0040_0028);
    chk("drop_req", {31'b0, imem_req}, 32'd1);
    chk("drop_valid", {31'b0, if_id_valid}, 32'd0);
    chk("drop_new_pc", new_pc, 32'h0040_0100);
    cyc(L, 1, L, L, 32'h0); chk("after_drop_addr", imem_addr, 32'h0040_0100); chk("after_drop_valid", {31'b0, if_id_valid}, 32'd0);
    cyc(L, 1, L, L, 32'h0); push(32'h0040_0100, 32'h0040_0104);
    // redirect and stall together in HOLD
    cyc(L, 0, L, L, 32'h0);
    cyc(L, 0, H, L, 32'h0);
    cyc(L, 0, H, H, 32'h0040_0100); chk("flush_new_pc", new_pc, 32'h0040_0100); chk("flush_hold_req", {31'b0, imem_req}, 32'd0);
    cyc(L, 0, L, L, 32'h0);
    chk("flush_valid", {31'b0, if_id_valid}, 32'd0);
    chk("flush_fetch_req", {31'b0, imem_req}, 32'd1);
    chk("flush_fetch_addr", imem_addr, 32'h0040_0100);
    push(32'h0040_0100, 32'h0040_0104);
    // reset while in DROP
    cyc(L, 1, L, H, 32'h0040_0200);
    cyc(H, 1, L, L, 32'h0); chk("drop_rst_req", {31'b0, imem_req}, 32'd0); chk("drop_rst_new_pc", new_pc, RPC);
    cyc(H, 1, L, L, 32'h0);
    chk("drop_rst_valid", {31'b0, if_id_valid}, 32'd0);
    chk("drop_rst_req2", {31'b0, imem_req}, 32'd0);
    chk("drop_rst_new_pc2", new_pc, RPC);
    cyc(L, 1, L, L, 32'h0); chk("post_rst_req", {31'b0, imem_req}, 32'd1); chk("post_rst_addr", imem_addr, RPC);
    cyc(L, 1, L, L, 32'h0); push(32'h0040_0000, 32'h0040_0004);
    // PC wrap at the top of the address space
    cyc(L, 0, L, H, 32'hFFFF_FFFC);
    cyc(L, 0, L, L, 32'h0); chk("wrap_new_pc", new_pc, 32'h0); push(32'hFFFF_FFFC, 32'h0);
    cyc(H, 0, L, L, 32'h0);
    cyc(H, 0, L, L, 32'h0);
    cyc(H, 0, L, L, 32'h0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
